// File: rtl/imem_stream_loader_pkg.sv
// Shared types and widths for the instruction-memory stream loader.
package imem_stream_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WCNT_W = 9;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_wr_t;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte stream valid/ready handshake between a byte source and the loader.
interface imem_stream_loader_if;
    import imem_stream_loader_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/imem_stream_loader_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; the word is presented
// combinationally in the same cycle its fourth byte is accepted.
module imem_word_packer
    import imem_stream_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] word_c,
    output logic              word_valid_c
);

    localparam int unsigned LO_W = DATA_W - BYTE_W;

    logic [1:0]      idx_q, idx_d;
    logic [LO_W-1:0] lo_q, lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 2'd0;
            lo_q  <= '0;
        end else begin
            idx_q <= idx_d;
            lo_q  <= lo_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        lo_d  = lo_q;
        if (clear_i) begin
            idx_d = 2'd0;
        end else if (valid_i) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    lo_d[7:0]   = byte_i;
                2'd1:    lo_d[15:8]  = byte_i;
                2'd2:    lo_d[23:16] = byte_i;
                default: lo_d        = lo_q;
            endcase
        end
    end

    assign word_c       = {byte_i, lo_q};
    assign word_valid_c = valid_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: parses sync/length/payload/checksum frames, writes words into
// instruction memory and holds the core in reset until a good image lands.
module imem_stream_loader
    import imem_stream_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDRESS = 32'd0,
    parameter logic [ADDR_W-1:0] STOP_ADDRESS  = 32'd1023,
    parameter logic [BYTE_W-1:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    imem_stream_loader_if.slave in_if,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [WCNT_W-1:0] words_written
);

    localparam logic [ADDR_W-1:0] MAX_WORDS = (STOP_ADDRESS - START_ADDRESS + 32'd1) >> 2;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    mem_wr_t           wr_q, wr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hold_q, hold_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic              in_ready_c;
    logic              accept_c;
    logic              pk_clear_c;
    logic [DATA_W-1:0] pk_word_c;
    logic              pk_word_valid_c;

    assign in_ready_c     = (state_q != DONE) && (state_q != ERROR);
    assign accept_c       = in_if.in_valid && in_ready_c;
    assign in_if.in_ready = in_ready_c;

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pk_clear_c),
        .byte_i       (in_if.in_data),
        .valid_i      (accept_c && (state_q == DATA)),
        .word_c       (pk_word_c),
        .word_valid_c (pk_word_valid_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            len_q   <= '0;
            csum_q  <= '0;
            wr_q    <= '{we: 1'b0, addr: START_ADDRESS, wdata: '0};
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            error_q <= error_d;
            hold_q  <= hold_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        wr_d       = wr_q;
        wr_d.we    = 1'b0;
        done_d     = done_q;
        error_d    = error_q;
        hold_d     = hold_q;
        wcnt_d     = wcnt_q;
        pk_clear_c = 1'b0;

        case (state_q)
            SYNC: begin
                // Hunting for a frame start; keep the packer aligned to byte 0.
                pk_clear_c = 1'b1;
                if (accept_c && (in_if.in_data == SYNC_BYTE)) begin
                    state_d = LEN_LO;
                    csum_d  = '0;
                end
            end
            LEN_LO: begin
                if (accept_c) begin
                    len_d   = {len_q[LEN_W-1:BYTE_W], in_if.in_data};
                    csum_d  = csum_q ^ in_if.in_data;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept_c) begin
                    len_d  = {in_if.in_data, len_q[BYTE_W-1:0]};
                    csum_d = csum_q ^ in_if.in_data;
                    if (ADDR_W'(len_d) > MAX_WORDS) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else if (len_d == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept_c) begin
                    csum_d = csum_q ^ in_if.in_data;
                    if (pk_word_valid_c) begin
                        wr_d.we    = 1'b1;
                        wr_d.addr  = START_ADDRESS + (ADDR_W'(wcnt_q) << 2);
                        wr_d.wdata = pk_word_c;
                        wcnt_d     = wcnt_q + WCNT_W'(1);
                        if (LEN_W'(wcnt_d) == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept_c) begin
                    if (in_if.in_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
                if (reload) begin
                    state_d    = SYNC;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    hold_d     = 1'b1;
                    wcnt_d     = '0;
                    pk_clear_c = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign mem_we        = wr_q.we;
    assign mem_addr      = wr_q.addr;
    assign mem_wdata     = wr_q.wdata;
    assign core_hold     = hold_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = wcnt_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: framing, packing, checksum, reload, reset.
module tb_imem_stream_loader;

    logic        clk;
    logic        rst;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [8:0]  words_written;

    imem_stream_loader_if sif ();

    imem_stream_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_if         (sif),
        .reload        (reload),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .core_hold     (core_hold),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [7:0]  s2     [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                                 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    int          gaps   [12] = '{0, 2, 1, 0, 3, 0, 1, 0, 2, 0, 1, 3};
    logic [63:0] exp_wr [2]  = '{64'h00000000_00000013, 64'h00000004_00100093};

    logic [63:0] wr_log[$];

    always #5 clk = ~clk;

    // Every write strobe is logged as {addr, data}, one entry per high cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_log.push_back({mem_addr, mem_wdata});
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            sif.in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        sif.in_data  = b;
        sif.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (sif.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tot_cnt++;
            $display("FAIL send_byte: byte %h never accepted within 20 cycles", b);
        end
    endtask

    task automatic pulse_reload();
        sif.in_valid = 1'b0;
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reload = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tot_cnt++;
        if ({core_hold, sif.in_ready, mem_we, done, error} !== 5'b11000)
            $display("FAIL reset_flags: got %b expected 11000 (hold,ready,we,done,err)",
                     {core_hold, sif.in_ready, mem_we, done, error});
        else pass_cnt++;
        tot_cnt++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset_bus: got addr %h data %h expected 0 0", mem_addr, mem_wdata);
        else pass_cnt++;
        tot_cnt++;
        if (words_written !== 9'd0)
            $display("FAIL reset_count: got %0d expected 0", words_written);
        else pass_cnt++;
    endtask

    task automatic test_good_frame();
        wr_log.delete();
        for (int i = 0; i < 12; i++) send_byte(s2[i], 0);
        sif.in_valid = 1'b0;
        tot_cnt++;
        if ({done, error, core_hold, sif.in_ready} !== 4'b1000)
            $display("FAIL good_status: got %b expected 1000 (done,err,hold,ready)",
                     {done, error, core_hold, sif.in_ready});
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        tot_cnt++;
        if (wr_log.size() !== 2)
            $display("FAIL good_write_count: got %0d expected 2", wr_log.size());
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tot_cnt++;
            if (i >= wr_log.size() || wr_log[i] !== exp_wr[i])
                $display("FAIL good_write%0d: got %h expected %h", i,
                         (i < wr_log.size()) ? wr_log[i] : 64'h0, exp_wr[i]);
            else pass_cnt++;
        end
        tot_cnt++;
        if (words_written !== 9'd2 || done !== 1'b1)
            $display("FAIL good_sticky: got words %0d done %b expected 2 1", words_written, done);
        else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        pulse_reload();
        wr_log.delete();
        for (int i = 0; i < 11; i++) send_byte(s2[i], 0);
        send_byte(8'h00, 0);
        sif.in_valid = 1'b0;
        tot_cnt++;
        if ({done, error, core_hold, sif.in_ready} !== 4'b0110)
            $display("FAIL badcs_status: got %b expected 0110 (done,err,hold,ready)",
                     {done, error, core_hold, sif.in_ready});
        else pass_cnt++;
        tot_cnt++;
        if (wr_log.size() !== 2)
            $display("FAIL badcs_write_count: got %0d expected 2", wr_log.size());
        else pass_cnt++;
        pulse_reload();
        tot_cnt++;
        if ({done, error, core_hold, sif.in_ready} !== 4'b0011 || words_written !== 9'd0)
            $display("FAIL reload_status: got %b words %0d expected 0011 words 0",
                     {done, error, core_hold, sif.in_ready}, words_written);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) send_byte(s2[i], 0);
        sif.in_valid = 1'b0;
        tot_cnt++;
        if ({done, error, core_hold} !== 3'b100)
            $display("FAIL reload_replay: got %b expected 100 (done,err,hold)",
                     {done, error, core_hold});
        else pass_cnt++;
    endtask

    task automatic test_bad_length();
        pulse_reload();
        wr_log.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        sif.in_valid = 1'b0;
        tot_cnt++;
        if ({done, error, core_hold, sif.in_ready} !== 4'b0110)
            $display("FAIL badlen_status: got %b expected 0110 (done,err,hold,ready)",
                     {done, error, core_hold, sif.in_ready});
        else pass_cnt++;
        repeat (4) @(posedge clk);
        #1;
        tot_cnt++;
        if (wr_log.size() !== 0)
            $display("FAIL badlen_writes: got %0d expected 0", wr_log.size());
        else pass_cnt++;
    endtask

    task automatic test_gaps_and_empty();
        pulse_reload();
        wr_log.delete();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        for (int i = 0; i < 12; i++) send_byte(s2[i], gaps[i]);
        sif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tot_cnt++;
        if (wr_log.size() !== 2)
            $display("FAIL gaps_write_count: got %0d expected 2", wr_log.size());
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tot_cnt++;
            if (i >= wr_log.size() || wr_log[i] !== exp_wr[i])
                $display("FAIL gaps_write%0d: got %h expected %h", i,
                         (i < wr_log.size()) ? wr_log[i] : 64'h0, exp_wr[i]);
            else pass_cnt++;
        end
        tot_cnt++;
        if ({done, error, core_hold} !== 3'b100)
            $display("FAIL gaps_status: got %b expected 100", {done, error, core_hold});
        else pass_cnt++;

        pulse_reload();
        wr_log.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        sif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tot_cnt++;
        if ({done, error, core_hold} !== 3'b100 || words_written !== 9'd0 || wr_log.size() !== 0)
            $display("FAIL empty_frame: got status %b words %0d writes %0d expected 100 0 0",
                     {done, error, core_hold}, words_written, wr_log.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        pulse_reload();
        wr_log.delete();
        for (int i = 0; i < 7; i++) send_byte(s2[i], 0);
        sif.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tot_cnt++;
        if ({core_hold, sif.in_ready, mem_we, done, error} !== 5'b11000 || words_written !== 9'd0)
            $display("FAIL midrst_status: got %b words %0d expected 11000 words 0",
                     {core_hold, sif.in_ready, mem_we, done, error}, words_written);
        else pass_cnt++;
        repeat (4) @(posedge clk);
        #1;
        tot_cnt++;
        if (wr_log.size() !== 1)
            $display("FAIL midrst_writes: got %0d expected 1", wr_log.size());
        else pass_cnt++;
        wr_log.delete();
        for (int i = 0; i < 12; i++) send_byte(s2[i], 0);
        sif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tot_cnt++;
        if (wr_log.size() !== 2 || wr_log[0] !== exp_wr[0] || wr_log[1] !== exp_wr[1])
            $display("FAIL midrst_replay_writes: got %0d writes expected 2 matching", wr_log.size());
        else pass_cnt++;
        tot_cnt++;
        if ({done, error, core_hold} !== 3'b100)
            $display("FAIL midrst_replay_status: got %b expected 100", {done, error, core_hold});
        else pass_cnt++;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        reload = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_data = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_gaps_and_empty();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
